// File: rtl/dadda_mac_acc.sv
// Saturating multiply-accumulate back end: sums a programmed number of unsigned
// multiplier products and returns the total over a valid/ready result port.
module dadda_mac_acc #(
    parameter int PROD_W = 33,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              overflow,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never depends on ready, and a held valid keeps its data stable.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam int PAD = ACC_W + 1 - PROD_W;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ACC_W-1:0]   acc_out_q, acc_out_d;
    logic               overflow_q, overflow_d;

    logic [ACC_W:0]     sum_ext;
    logic [ACC_W-1:0]   sum_sat;
    logic               beat;
    logic               last_beat;

    // Carry out of the widened sum means saturation; an all-ones accumulator
    // stays all-ones because any non-zero addend carries again.
    always_comb begin
        sum_ext = {1'b0, acc_q} + {{PAD{1'b0}}, prod_in};
        sum_sat = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    end

    assign beat      = (state_q == S_ACCUM) && prod_valid;
    assign last_beat = (cnt_q == (len_q - LEN_ONE));

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        acc_out_d  = acc_out_q;
        overflow_d = overflow_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    overflow_d = 1'b0;
                    if (len != '0) begin
                        len_d   = len;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_ACCUM;
                    end else begin
                        acc_out_d = '0;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    acc_d      = sum_sat;
                    cnt_d      = cnt_q + LEN_ONE;
                    overflow_d = overflow_q | sum_ext[ACC_W];
                    if (last_beat) begin
                        acc_out_d = sum_sat;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (acc_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            acc_out_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            acc_out_q  <= acc_out_d;
            overflow_q <= overflow_d;
        end
    end

    assign prod_ready = (state_q == S_ACCUM);
    assign acc_valid  = (state_q == S_HOLD);
    assign busy       = (state_q != S_IDLE);
    assign acc_out    = acc_out_q;
    assign overflow   = overflow_q;
    assign state_dbg  = state_q;

endmodule
